// File: rtl/eth_idma_multi_chan_fe.sv
// Multi-channel descriptor front-end for the Ethernet iDMA wrapper: per-channel
// queues, round-robin issue to one iDMA request port, in-order completion routing.
module eth_idma_multi_chan_fe #(
    parameter int unsigned NumChannels         = 2,
    parameter int unsigned QueueDepth          = 4,
    parameter int unsigned MaxOutstanding      = 4,
    parameter int unsigned AddrWidth           = 64,
    parameter int unsigned TFLenWidth          = 32,
    parameter int unsigned ProtWidth           = 3,
    parameter bit          RejectZeroTransfers = 1'b1,
    parameter int unsigned CntWidth            = 16,
    localparam int unsigned LvlWidth           = $clog2(QueueDepth + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumChannels-1:0]            ch_req_valid_i,
    output logic [NumChannels-1:0]            ch_req_ready_o,
    input  logic [NumChannels*AddrWidth-1:0]  ch_src_addr_i,
    input  logic [NumChannels*AddrWidth-1:0]  ch_dst_addr_i,
    input  logic [NumChannels*TFLenWidth-1:0] ch_len_i,
    input  logic [NumChannels*ProtWidth-1:0]  ch_src_prot_i,
    input  logic [NumChannels*ProtWidth-1:0]  ch_dst_prot_i,
    output logic                              idma_req_valid_o,
    input  logic                              idma_req_ready_i,
    output logic [AddrWidth-1:0]              idma_src_addr_o,
    output logic [AddrWidth-1:0]              idma_dst_addr_o,
    output logic [TFLenWidth-1:0]             idma_len_o,
    output logic [ProtWidth-1:0]              idma_src_prot_o,
    output logic [ProtWidth-1:0]              idma_dst_prot_o,
    input  logic                              idma_rsp_valid_i,
    input  logic                              idma_rsp_error_i,
    output logic                              idma_rsp_ready_o,
    output logic [NumChannels-1:0]            ch_done_o,
    output logic [NumChannels-1:0]            ch_error_o,
    output logic [NumChannels*CntWidth-1:0]   ch_done_cnt_o,
    output logic [NumChannels*LvlWidth-1:0]   ch_level_o,
    output logic                              busy_o
);

    localparam int unsigned PtrWidth = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
    localparam int unsigned ChWidth  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned OrdWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned IfWidth  = $clog2(MaxOutstanding + 1);
    localparam int unsigned DescW    = 2 * AddrWidth + TFLenWidth + 2 * ProtWidth;

    // Descriptor layout: {src_addr, dst_addr, len, src_prot, dst_prot}
    localparam int unsigned OffSp  = ProtWidth;
    localparam int unsigned OffLen = 2 * ProtWidth;
    localparam int unsigned OffDst = OffLen + TFLenWidth;
    localparam int unsigned OffSrc = OffDst + AddrWidth;

    logic [NumChannels-1:0] q_nonempty;
    logic [NumChannels-1:0] pop_vec;
    logic [DescW-1:0]       head_desc [NumChannels];

    logic                   stage_valid_q, stage_valid_d;
    logic [DescW-1:0]       stage_desc_q, stage_desc_d;
    logic [ChWidth-1:0]     stage_ch_q, stage_ch_d;
    logic [ChWidth-1:0]     rr_q, rr_d;
    logic [IfWidth-1:0]     in_flight_q, in_flight_d;
    logic [OrdWidth-1:0]    ord_wr_ptr_q, ord_wr_ptr_d;
    logic [OrdWidth-1:0]    ord_rd_ptr_q, ord_rd_ptr_d;
    logic [ChWidth-1:0]     ord_mem_q [MaxOutstanding];

    logic                   req_hs;
    logic                   rsp_hs;
    logic [IfWidth-1:0]     in_flight_next;
    logic                   winner_found;
    logic [ChWidth-1:0]     winner;
    logic                   load;
    logic [ChWidth-1:0]     rsp_ch;

    function automatic logic [ChWidth-1:0] rr_idx(input logic [ChWidth-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= NumChannels) s = s - NumChannels;
        return ChWidth'(s);
    endfunction

    function automatic logic [OrdWidth-1:0] ord_inc(input logic [OrdWidth-1:0] p);
        if (p == OrdWidth'(MaxOutstanding - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign rsp_ch = ord_mem_q[ord_rd_ptr_q];

    genvar gi;
    generate
        for (gi = 0; gi < NumChannels; gi++) begin : g_ch
            logic [DescW-1:0]    mem_q [QueueDepth];
            logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
            logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
            logic [LvlWidth-1:0] level_q, level_d;
            logic [CntWidth-1:0] cnt_q, cnt_d;
            logic                done_q, done_d;
            logic                err_q, err_d;
            logic                full;
            logic                accept;
            logic                zero_len;
            logic                push;
            logic [DescW-1:0]    push_desc;

            assign push_desc = {ch_src_addr_i[gi*AddrWidth +: AddrWidth],
                                ch_dst_addr_i[gi*AddrWidth +: AddrWidth],
                                ch_len_i[gi*TFLenWidth +: TFLenWidth],
                                ch_src_prot_i[gi*ProtWidth +: ProtWidth],
                                ch_dst_prot_i[gi*ProtWidth +: ProtWidth]};

            // Ready reflects only the current level; a same-cycle pop does not free a slot.
            assign full     = (level_q == LvlWidth'(QueueDepth));
            assign accept   = ch_req_valid_i[gi] && !full;
            assign zero_len = RejectZeroTransfers && (ch_len_i[gi*TFLenWidth +: TFLenWidth] == '0);
            assign push     = accept && !zero_len;

            assign ch_req_ready_o[gi] = !full;
            assign q_nonempty[gi]     = (level_q != '0);
            assign head_desc[gi]      = mem_q[rd_ptr_q];

            always_comb begin
                wr_ptr_d = wr_ptr_q + PtrWidth'(push);
                rd_ptr_d = rd_ptr_q + PtrWidth'(pop_vec[gi]);
                level_d  = level_q + LvlWidth'(push) - LvlWidth'(pop_vec[gi]);
                done_d   = rsp_hs && (rsp_ch == ChWidth'(gi));
                err_d    = (done_d && idma_rsp_error_i) || (accept && zero_len);
                cnt_d    = cnt_q + CntWidth'(done_d);
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    level_q  <= '0;
                    cnt_q    <= '0;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    level_q  <= level_d;
                    cnt_q    <= cnt_d;
                    done_q   <= done_d;
                    err_q    <= err_d;
                end
            end

            always_ff @(posedge clk_i) begin
                if (push) mem_q[wr_ptr_q] <= push_desc;
            end

            assign ch_done_o[gi]                          = done_q;
            assign ch_error_o[gi]                         = err_q;
            assign ch_done_cnt_o[gi*CntWidth +: CntWidth] = cnt_q;
            assign ch_level_o[gi*LvlWidth +: LvlWidth]    = level_q;
        end
    endgenerate

    always_comb begin
        req_hs         = stage_valid_q && idma_req_ready_i;
        rsp_hs         = (in_flight_q != '0) && idma_rsp_valid_i;
        in_flight_next = in_flight_q + IfWidth'(req_hs) - IfWidth'(rsp_hs);

        winner_found = 1'b0;
        winner       = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (!winner_found && q_nonempty[rr_idx(rr_q, i)]) begin
                winner_found = 1'b1;
                winner       = rr_idx(rr_q, i);
            end
        end

        // A new request may only be staged if it can still fit in the outstanding window.
        load = (!stage_valid_q || req_hs) && winner_found && (in_flight_next < IfWidth'(MaxOutstanding));

        pop_vec = '0;
        if (load) pop_vec[winner] = 1'b1;

        rr_d          = rr_q;
        stage_valid_d = stage_valid_q;
        stage_desc_d  = stage_desc_q;
        stage_ch_d    = stage_ch_q;
        if (load) begin
            rr_d          = (winner == ChWidth'(NumChannels - 1)) ? '0 : winner + 1'b1;
            stage_valid_d = 1'b1;
            stage_desc_d  = head_desc[winner];
            stage_ch_d    = winner;
        end else if (req_hs) begin
            stage_valid_d = 1'b0;
        end

        in_flight_d  = in_flight_next;
        ord_wr_ptr_d = req_hs ? ord_inc(ord_wr_ptr_q) : ord_wr_ptr_q;
        ord_rd_ptr_d = rsp_hs ? ord_inc(ord_rd_ptr_q) : ord_rd_ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_valid_q <= 1'b0;
            stage_desc_q  <= '0;
            stage_ch_q    <= '0;
            rr_q          <= '0;
            in_flight_q   <= '0;
            ord_wr_ptr_q  <= '0;
            ord_rd_ptr_q  <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_desc_q  <= stage_desc_d;
            stage_ch_q    <= stage_ch_d;
            rr_q          <= rr_d;
            in_flight_q   <= in_flight_d;
            ord_wr_ptr_q  <= ord_wr_ptr_d;
            ord_rd_ptr_q  <= ord_rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_hs) ord_mem_q[ord_wr_ptr_q] <= stage_ch_q;
    end

    assign idma_req_valid_o = stage_valid_q;
    assign idma_src_addr_o  = stage_desc_q[OffSrc +: AddrWidth];
    assign idma_dst_addr_o  = stage_desc_q[OffDst +: AddrWidth];
    assign idma_len_o       = stage_desc_q[OffLen +: TFLenWidth];
    assign idma_src_prot_o  = stage_desc_q[OffSp +: ProtWidth];
    assign idma_dst_prot_o  = stage_desc_q[0 +: ProtWidth];
    assign idma_rsp_ready_o = (in_flight_q != '0);
    assign busy_o           = (|q_nonempty) || stage_valid_q || (in_flight_q != '0);

endmodule

// File: tb/tb_eth_idma_multi_chan_fe.sv
// Bench for eth_idma_multi_chan_fe: directed scenarios plus randomized traffic
// scored against a queue-based reference model of descriptors and completions.
`timescale 1ns/1ps
module tb_eth_idma_multi_chan_fe;
    localparam int NCH = 2;
    localparam int QD  = 4;
    localparam int MO  = 4;
    localparam int AW  = 64;
    localparam int LW  = 32;
    localparam int PW  = 3;
    localparam int CW  = 16;
    localparam int LVW = $clog2(QD + 1);

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [LW-1:0] len;
        logic [PW-1:0] sp;
        logic [PW-1:0] dp;
    } desc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NCH-1:0]    ch_req_valid = '0;
    logic [NCH-1:0]    ch_req_ready;
    logic [NCH*AW-1:0] ch_src = '0;
    logic [NCH*AW-1:0] ch_dst = '0;
    logic [NCH*LW-1:0] ch_len = '0;
    logic [NCH*PW-1:0] ch_sp  = '0;
    logic [NCH*PW-1:0] ch_dp  = '0;
    logic              req_valid;
    logic              req_ready = 1'b0;
    logic [AW-1:0]     req_src, req_dst;
    logic [LW-1:0]     req_len;
    logic [PW-1:0]     req_sp, req_dp;
    logic              rsp_valid = 1'b0;
    logic              rsp_error = 1'b0;
    logic              rsp_ready;
    logic [NCH-1:0]    done, err;
    logic [NCH*CW-1:0] cnt;
    logic [NCH*LVW-1:0] level;
    logic              busy;

    eth_idma_multi_chan_fe #(
        .NumChannels(NCH), .QueueDepth(QD), .MaxOutstanding(MO), .AddrWidth(AW),
        .TFLenWidth(LW), .ProtWidth(PW), .RejectZeroTransfers(1'b1), .CntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ch_req_valid_i(ch_req_valid), .ch_req_ready_o(ch_req_ready),
        .ch_src_addr_i(ch_src), .ch_dst_addr_i(ch_dst), .ch_len_i(ch_len),
        .ch_src_prot_i(ch_sp), .ch_dst_prot_i(ch_dp),
        .idma_req_valid_o(req_valid), .idma_req_ready_i(req_ready),
        .idma_src_addr_o(req_src), .idma_dst_addr_o(req_dst), .idma_len_o(req_len),
        .idma_src_prot_o(req_sp), .idma_dst_prot_o(req_dp),
        .idma_rsp_valid_i(rsp_valid), .idma_rsp_error_i(rsp_error), .idma_rsp_ready_o(rsp_ready),
        .ch_done_o(done), .ch_error_o(err), .ch_done_cnt_o(cnt), .ch_level_o(level), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending descriptors per channel, issued-but-unanswered channel order.
    desc_t          mq [NCH][$];
    int             issue_q[$];
    int             issued_log[$];
    int             done_log[$];
    int             exp_cnt [NCH];
    logic [NCH-1:0] pend_done = '0;
    logic [NCH-1:0] pend_err  = '0;
    int             outstanding = 0;
    int             req_hs_cnt = 0;
    bit             stall_prev = 0;
    desc_t          stall_desc;
    bit             mon_en = 0;
    bit             verbose = 1;
    desc_t          mon_d;
    int             mon_c;
    int             mon_k;
    bit             mon_ok;

    always @(negedge clk) begin
        if (mon_en) begin
            check_val("done_vec", done, pend_done);
            check_val("err_vec", err, pend_err);
            for (int c = 0; c < NCH; c++) begin
                if (pend_done[c]) done_log.push_back(c);
                check_val("done_cnt", cnt[c*CW +: CW], 64'(exp_cnt[c] % 65536));
            end
            pend_done = '0;
            pend_err  = '0;
            check_val("rsp_ready", rsp_ready, outstanding > 0);

            if (stall_prev) begin
                check_val("stall_valid", req_valid, 1);
                check_val("stall_src", req_src, stall_desc.src);
                check_val("stall_len", req_len, stall_desc.len);
            end
            stall_prev     = req_valid && !req_ready;
            stall_desc.src = req_src;
            stall_desc.len = req_len;

            if (rsp_valid && rsp_ready && issue_q.size() > 0) begin
                mon_k = issue_q.pop_front();
                pend_done[mon_k] = 1'b1;
                if (rsp_error) pend_err[mon_k] = 1'b1;
                exp_cnt[mon_k]++;
                outstanding--;
                if (verbose) $display("[%0t] completion ch%0d error=%0d", $time, mon_k, rsp_error);
            end

            if (req_valid && req_ready) begin
                mon_c  = int'(req_src[63:56]);
                mon_ok = (mon_c < NCH) && (mq[mon_c].size() > 0);
                check_val("issue_pending", mon_ok, 1);
                if (mon_ok) begin
                    mon_d = mq[mon_c].pop_front();
                    check_val("issue_src", req_src, mon_d.src);
                    check_val("issue_dst", req_dst, mon_d.dst);
                    check_val("issue_len", req_len, mon_d.len);
                    check_val("issue_sprot", req_sp, mon_d.sp);
                    check_val("issue_dprot", req_dp, mon_d.dp);
                    issue_q.push_back(mon_c);
                    issued_log.push_back(mon_c);
                    outstanding++;
                    req_hs_cnt++;
                    check_val("outstanding_le_max", outstanding <= MO, 1);
                    if (verbose) $display("[%0t] issue ch%0d src=%h len=0x%0h", $time, mon_c, req_src, req_len);
                end
            end

            for (int c = 0; c < NCH; c++) begin
                if (ch_req_valid[c] && ch_req_ready[c]) begin
                    if (ch_len[c*LW +: LW] == '0) begin
                        pend_err[c] = 1'b1;
                    end else begin
                        mon_d.src = ch_src[c*AW +: AW];
                        mon_d.dst = ch_dst[c*AW +: AW];
                        mon_d.len = ch_len[c*LW +: LW];
                        mon_d.sp  = ch_sp[c*PW +: PW];
                        mon_d.dp  = ch_dp[c*PW +: PW];
                        mq[c].push_back(mon_d);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            exp_cnt[c] = 0;
        end
        issue_q.delete();
        issued_log.delete();
        done_log.delete();
        pend_done   = '0;
        pend_err    = '0;
        outstanding = 0;
        req_hs_cnt  = 0;
        stall_prev  = 0;
    endtask

    task automatic do_reset();
        mon_en       = 0;
        rst          = 1'b1;
        ch_req_valid = '0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_error    = 1'b0;
        repeat (2) tick();
        clear_model();
        rst    = 1'b0;
        mon_en = 1;
    endtask

    function automatic logic [AW-1:0] mk_src(input int c, input int seq);
        return {8'(c), 24'(seq), 32'(seq * 64)};
    endfunction

    task automatic set_ch(input int c, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] l, input logic [PW-1:0] sp, input logic [PW-1:0] dp);
        ch_src[c*AW +: AW] = s;
        ch_dst[c*AW +: AW] = d;
        ch_len[c*LW +: LW] = l;
        ch_sp[c*PW +: PW]  = sp;
        ch_dp[c*PW +: PW]  = dp;
    endtask

    task automatic push(input int c, input logic [AW-1:0] s, input logic [LW-1:0] l);
        set_ch(c, s, s ^ 64'h0000_1000_0000_0000, l, 3'd0, 3'd5);
        ch_req_valid[c] = 1'b1;
        tick();
        ch_req_valid[c] = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, busy, 0);
        tick();
        tick();
    endtask

    int seq = 0;
    int snap;

    initial begin
        // Reset values while reset is held
        #2;
        check_val("rst_req_valid", req_valid, 0);
        check_val("rst_busy", busy, 0);
        do_reset();
        check_val("rst_req_ready", ch_req_ready, 2'b11);
        check_val("rst_level", level, 0);
        check_val("rst_cnt", cnt, 0);
        check_val("rst_rsp_ready", rsp_ready, 0);

        // Single descriptor: two-cycle latency, exact fields, one completion
        req_ready = 1'b1;
        set_ch(0, 64'h0, 64'h0, 32'h40, 3'd0, 3'd5);
        ch_req_valid[0] = 1'b1;
        tick();
        ch_req_valid[0] = 1'b0;
        check_val("t1_valid_early", req_valid, 0);
        tick();
        check_val("t1_valid", req_valid, 1);
        check_val("t1_src", req_src, 64'h0);
        check_val("t1_dst", req_dst, 64'h0);
        check_val("t1_len", req_len, 64'h40);
        check_val("t1_sprot", req_sp, 0);
        check_val("t1_dprot", req_dp, 5);
        tick();
        check_val("t1_rsp_ready", rsp_ready, 1);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check_val("t1_done", done[0], 1);
        check_val("t1_cnt0", cnt[0 +: CW], 1);
        check_val("t1_busy", busy, 0);
        tick();

        // Round-robin: three descriptors per channel, immediate responses
        do_reset();
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ch(0, mk_src(0, i + 1), 64'h100, 32'h80 + 32'(i), 3'd0, 3'd5);
            set_ch(1, mk_src(1, i + 1), 64'h200, 32'h90 + 32'(i), 3'd5, 3'd0);
            ch_req_valid = 2'b11;
            tick();
        end
        ch_req_valid = '0;
        wait_idle(40, "t2_idle");
        rsp_valid = 1'b0;
        check_val("t2_issued", issued_log.size(), 6);
        check_val("t2_done_n", done_log.size(), 6);
        for (int i = 0; i < 6 && i < issued_log.size() && i < done_log.size(); i++) begin
            check_val("t2_issue_order", issued_log[i], i % 2);
            check_val("t2_done_order", done_log[i], i % 2);
        end
        check_val("t2_cnt0", cnt[0 +: CW], 3);
        check_val("t2_cnt1", cnt[CW +: CW], 3);

        // Back-pressure: stall, queue fill to depth, refused push
        do_reset();
        for (int i = 0; i < 5; i++) push(0, mk_src(0, i + 1), 32'h100);
        check_val("t3_ready0", ch_req_ready[0], 0);
        check_val("t3_level_full", level[0 +: LVW], QD);
        push(0, mk_src(0, 9), 32'h100);
        check_val("t3_level_after_refuse", level[0 +: LVW], QD);
        repeat (10) tick();
        check_val("t3_valid_held", req_valid, 1);
        check_val("t3_src_held", req_src, mk_src(0, 1));
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        wait_idle(60, "t3_idle");
        rsp_valid = 1'b0;
        check_val("t3_cnt0", cnt[0 +: CW], 5);

        // Outstanding limit: no responses, only MO requests go out
        do_reset();
        req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ch(0, mk_src(0, i + 1), 64'h300, 32'h20, 3'd0, 3'd0);
            set_ch(1, mk_src(1, i + 1), 64'h400, 32'h30, 3'd0, 3'd0);
            ch_req_valid = 2'b11;
            tick();
        end
        ch_req_valid = '0;
        repeat (12) tick();
        check_val("t4_hs_cnt", req_hs_cnt, MO);
        check_val("t4_rsp_ready", rsp_ready, 1);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check_val("t4_fifth_valid", req_valid, 1);
        tick();
        check_val("t4_fifth_hs", req_hs_cnt, MO + 1);
        rsp_valid = 1'b1;
        wait_idle(60, "t4_idle");
        rsp_valid = 1'b0;

        // Zero-length reject and errored completion
        do_reset();
        req_ready = 1'b1;
        push(1, mk_src(1, 1), 32'h0);
        check_val("t5_reject_err", err[1], 1);
        check_val("t5_level1", level[LVW +: LVW], 0);
        tick();
        check_val("t5_err_clear", err[1], 0);
        check_val("t5_no_req", req_valid, 0);
        check_val("t5_cnt1_zero", cnt[CW +: CW], 0);
        push(1, mk_src(1, 2), 32'h80);
        tick();
        tick();
        rsp_valid = 1'b1;
        rsp_error = 1'b1;
        tick();
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        check_val("t5_done1", done[1], 1);
        check_val("t5_err1", err[1], 1);
        check_val("t5_cnt1", cnt[CW +: CW], 1);
        tick();

        // Asynchronous reset mid-cycle with traffic in flight
        do_reset();
        req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ch(0, mk_src(0, i + 1), 64'h500, 32'h10, 3'd0, 3'd0);
            set_ch(1, mk_src(1, i + 1), 64'h600, 32'h10, 3'd0, 3'd0);
            ch_req_valid = 2'b11;
            tick();
        end
        ch_req_valid = '0;
        tick();
        tick();
        check_val("t6_inflight", rsp_ready, 1);
        #2;
        mon_en = 0;
        rst = 1'b1;
        #1;
        check_val("t6_req_valid", req_valid, 0);
        check_val("t6_rsp_ready", rsp_ready, 0);
        check_val("t6_busy", busy, 0);
        check_val("t6_level", level, 0);
        check_val("t6_cnt", cnt, 0);
        check_val("t6_done", done, 0);
        check_val("t6_err", err, 0);
        check_val("t6_ready", ch_req_ready, 2'b11);
        tick();
        #2;
        rst = 1'b0;
        clear_model();
        rsp_valid = 1'b1;
        tick();
        check_val("t6_late_rsp_ready", rsp_ready, 0);
        tick();
        check_val("t6_late_done", done, 0);
        rsp_valid = 1'b0;
        mon_en = 1;

        // Randomized traffic against the scoreboard
        do_reset();
        verbose = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                seq++;
                set_ch(c, mk_src(c, seq), {32'($urandom), 32'($urandom)},
                       ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(1, 4096)),
                       PW'($urandom_range(0, 7)), PW'($urandom_range(0, 7)));
                ch_req_valid[c] = ($urandom_range(0, 2) == 0);
            end
            req_ready = ($urandom_range(0, 3) != 0);
            rsp_valid = ($urandom_range(0, 2) == 0);
            rsp_error = ($urandom_range(0, 7) == 0);
            tick();
        end
        ch_req_valid = '0;
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_error = 1'b0;
        wait_idle(300, "rand_idle");
        rsp_valid = 1'b0;
        snap = mq[0].size() + mq[1].size() + issue_q.size();
        check_val("rand_model_empty", snap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
